// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the mem_arbiter RAM-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IC_BURST,
        LS_READ,
        LS_WRITE
    } arb_state_e;

    typedef enum logic {
        OWN_IC  = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE     = 2'd0;
    localparam logic [1:0] SIZE_HALF     = 2'd1;
    localparam logic [1:0] SIZE_WORD     = 2'd2;
    localparam logic [1:0] SIZE_WORD_ALT = 2'd3;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE:                return 3'd1;
            SIZE_HALF:                return 3'd2;
            SIZE_WORD, SIZE_WORD_ALT: return 3'd4;
            default:                  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_lsu_byte_packer.sv
// Serialises one LSU access into little-endian byte beats and assembles load data.
module lsu_byte_packer
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rd_active,
    input  logic                  wr_active,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [1:0]            lsu_size,
    input  logic [31:0]           lsu_wdata,
    input  logic [7:0]            mem_din,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [7:0]            wr_byte,
    output logic                  rd_last,
    output logic                  wr_last,
    output logic                  done,
    output logic [31:0]           rdata
);

    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            nbytes_q <= 3'd1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            nbytes_q <= nbytes_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
        end
    end

    assign rd_last   = (cnt_q == nbytes_q);
    assign wr_last   = (cnt_q == (nbytes_q - 3'd1));
    // Address wraps naturally at 2^ADDR_WIDTH.
    assign beat_addr = addr_q + ADDR_WIDTH'(cnt_q);
    assign done      = done_q;
    assign rdata     = rdata_q;

    always_comb begin
        case (cnt_q[1:0])
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        nbytes_d = nbytes_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        if (start) begin
            cnt_d    = '0;
            nbytes_d = size_to_bytes(lsu_size);
            addr_d   = lsu_addr;
            wdata_d  = lsu_wdata;
            rdata_d  = '0;
        end else if (wr_active) begin
            if (wr_last) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if (rd_active) begin
            // mem_din lags the address by one beat, so beat k lands when cnt = k+1.
            case (cnt_q)
                3'd1:    rdata_d[7:0]   = mem_din;
                3'd2:    rdata_d[15:8]  = mem_din;
                3'd3:    rdata_d[23:16] = mem_din;
                3'd4:    rdata_d[31:24] = mem_din;
                default: ;
            endcase
            if (rd_last) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between icache line fills and the LSU.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int LINE_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_get_en,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_out_en,
    output logic [7:0]            ic_content,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [1:0]            lsu_size,
    input  logic [31:0]           lsu_wdata,
    output logic                  lsu_done,
    output logic [31:0]           lsu_rdata,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    output logic [7:0]            mem_dout,
    input  logic [7:0]            mem_din
);

    localparam int IC_CW = $clog2(LINE_BYTES + 1);

    arb_state_e            state_q, state_d;
    logic [IC_CW-1:0]      ic_cnt_q, ic_cnt_d;
    logic                  lsu_start;
    logic                  lsu_want;
    logic                  lsu_wins;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [7:0]            wr_byte;
    logic                  rd_last;
    logic                  wr_last;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_owner_q, last_owner_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ic_cnt_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_IC;
`endif
        end else begin
            state_q      <= state_d;
            ic_cnt_q     <= ic_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ic_cnt_d  = ic_cnt_q;
        lsu_start = 1'b0;
        // A request still high during its own done pulse is the one just finished.
        lsu_want  = lsu_req && !lsu_done;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
        lsu_wins     = lsu_want && (!ic_get_en || (last_owner_q == OWN_IC));
`else
        lsu_wins     = lsu_want;
`endif
        case (state_q)
            IDLE: begin
                if (lsu_wins) begin
                    state_d   = lsu_we ? LS_WRITE : LS_READ;
                    lsu_start = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = OWN_LSU;
`endif
                end else if (ic_get_en) begin
                    state_d  = IC_BURST;
                    ic_cnt_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = OWN_IC;
`endif
                end
            end
            IC_BURST: begin
                if (ic_cnt_q == IC_CW'(LINE_BYTES)) begin
                    state_d = IDLE;
                end else begin
                    ic_cnt_d = ic_cnt_q + 1'b1;
                end
            end
            LS_READ: begin
                if (rd_last) state_d = IDLE;
            end
            LS_WRITE: begin
                if (wr_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_a      = '0;
        mem_wr     = 1'b0;
        mem_dout   = '0;
        ic_out_en  = 1'b0;
        ic_content = '0;
        case (state_q)
            IC_BURST: begin
                if (ic_cnt_q < IC_CW'(LINE_BYTES)) mem_a = ic_addr;
                if (ic_cnt_q != '0) begin
                    ic_out_en  = 1'b1;
                    ic_content = mem_din;
                end
            end
            LS_READ: begin
                if (!rd_last) mem_a = beat_addr;
            end
            LS_WRITE: begin
                mem_a    = beat_addr;
                // The RAM commits on the reset edge too, so suppress the strobe there.
                mem_wr   = !rst;
                mem_dout = wr_byte;
            end
            default: ;
        endcase
    end

    lsu_byte_packer #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .start     (lsu_start),
        .rd_active (state_q == LS_READ),
        .wr_active (state_q == LS_WRITE),
        .lsu_addr  (lsu_addr),
        .lsu_size  (lsu_size),
        .lsu_wdata (lsu_wdata),
        .mem_din   (mem_din),
        .beat_addr (beat_addr),
        .wr_byte   (wr_byte),
        .rd_last   (rd_last),
        .wr_last   (wr_last),
        .done      (lsu_done),
        .rdata     (lsu_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random traffic against a byte-array model.
module tb_mem_arbiter;

    localparam int LINE = 4;
    localparam int MEMSZ = 131072;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_get_en = 1'b0;
    logic [16:0] ic_addr;
    logic        ic_out_en;
    logic [7:0]  ic_content;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [16:0] lsu_addr = '0;
    logic [1:0]  lsu_size = '0;
    logic [31:0] lsu_wdata = '0;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic [16:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = '0;

    logic [7:0]  ram [0:MEMSZ-1];
    logic [7:0]  ref_mem [0:MEMSZ-1];
    int          cyc = 0;
    int          ic_rx = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [16:0] ic_base = '0;
    logic        ref_last_lsu = 1'b0;
    logic        mon_en = 1'b0;

    typedef struct { logic is_load; logic [31:0] data; } lsu_exp_t;
    typedef struct { logic [16:0] a; logic [7:0] d; } wr_exp_t;
    logic [7:0] ic_q[$];
    lsu_exp_t   lsu_q[$];
    wr_exp_t    wr_q[$];
    lsu_exp_t   mon_le;
    wr_exp_t    mon_we;
    logic [7:0] mon_ib;

    // The icache steps its address as bytes come back: beat k is presented once k bytes are in flight.
    assign ic_addr = ic_base + 17'(ic_rx) + (ic_out_en ? 17'd1 : 17'd0);

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_get_en(ic_get_en), .ic_addr(ic_addr), .ic_out_en(ic_out_en), .ic_content(ic_content),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
        .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_din <= ram[mem_a];
        if (mem_wr) ram[mem_a] = mem_dout;
        if (!ic_get_en) ic_rx <= 0;
        else if (ic_out_en) ic_rx <= ic_rx + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (ic_out_en) begin
                if (ic_q.size() == 0) fail("ic_unexpected");
                else begin
                    mon_ib = ic_q.pop_front();
                    chk("ic_byte", 32'(ic_content), 32'(mon_ib));
                end
            end
            if (lsu_done) begin
                if (lsu_q.size() == 0) fail("lsu_done_unexpected");
                else begin
                    mon_le = lsu_q.pop_front();
                    if (mon_le.is_load) chk("lsu_rdata", lsu_rdata, mon_le.data);
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) fail("wr_unexpected");
                else begin
                    mon_we = wr_q.pop_front();
                    chk("wr_addr", 32'(mem_a), 32'(mon_we.a));
                    chk("wr_data", 32'(mem_dout), 32'(mon_we.d));
                end
            end
            if (ic_out_en && (lsu_done || mem_wr)) fail("ic_lsu_overlap");
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    task automatic set_byte(input logic [16:0] a, input logic [7:0] d);
        ram[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic ic_expect(input logic [16:0] base);
        for (int k = 0; k < LINE; k++) ic_q.push_back(ref_mem[base + 17'(k)]);
    endtask

    task automatic lsu_expect(input logic we, input logic [16:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] v;
        logic [16:0] ak;
        v = '0;
        for (int k = 0; k < nbytes(sz); k++) begin
            ak = a + 17'(k);
            if (we) begin
                ref_mem[ak] = wd[8*k +: 8];
                wr_q.push_back('{a: ak, d: wd[8*k +: 8]});
            end else begin
                v[8*k +: 8] = ref_mem[ak];
            end
        end
        lsu_q.push_back('{is_load: !we, data: v});
    endtask

    task automatic ic_txn(input logic [16:0] base, output int issue, output int first, output int last);
        bit ok;
        ok = 0;
        ic_base = base;
        ic_get_en = 1'b1;
        issue = cyc;
        first = -1;
        last = -1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (ic_out_en) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (ic_rx == LINE) begin ok = 1; break; end
        end
        ic_get_en = 1'b0;
        if (!ok) fail("ic_timeout");
    endtask

    task automatic lsu_txn(input logic we, input logic [16:0] a, input logic [1:0] sz, input logic [31:0] wd,
                           output int issue, output int done_c);
        lsu_we = we; lsu_addr = a; lsu_size = sz; lsu_wdata = wd;
        lsu_req = 1'b1;
        issue = cyc;
        done_c = -1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (lsu_done) begin done_c = cyc; break; end
        end
        lsu_req = 1'b0;
        if (done_c < 0) fail("lsu_timeout");
    endtask

    task automatic gap();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic ic_only(input logic [16:0] base);
        int is, f, l;
        ic_expect(base);
        ic_txn(base, is, f, l);
        chk("ic_first_lat", 32'(f - is), 32'd2);
        chk("ic_last_lat", 32'(l - is), 32'(LINE + 1));
        ref_last_lsu = 1'b0;
    endtask

    task automatic lsu_only(input logic we, input logic [16:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int is, d;
        lsu_expect(we, a, sz, wd);
        lsu_txn(we, a, sz, wd, is, d);
        chk("lsu_done_lat", 32'(d - is), 32'(nbytes(sz) + (we ? 1 : 2)));
        ref_last_lsu = 1'b1;
    endtask

    task automatic conflict(input logic [16:0] base, input logic we, input logic [16:0] a,
                            input logic [1:0] sz, input logic [31:0] wd);
        int is_i, f, l, is_l, d;
        bit lsu_wins;
`ifdef ARB_ROUND_ROBIN_EN
        lsu_wins = !ref_last_lsu;
`else
        lsu_wins = 1;
`endif
        if (lsu_wins) begin
            lsu_expect(we, a, sz, wd);
            ic_expect(base);
        end else begin
            ic_expect(base);
            lsu_expect(we, a, sz, wd);
        end
        fork
            begin ic_txn(base, is_i, f, l); end
            begin lsu_txn(we, a, sz, wd, is_l, d); end
        join
        if (lsu_wins) begin
            chk("cf_lsu_lat", 32'(d - is_l), 32'(nbytes(sz) + (we ? 1 : 2)));
            chk("cf_ic_after_lsu", 32'(f - d), 32'd2);
        end else begin
            chk("cf_ic_lat", 32'(f - is_i), 32'd2);
            chk("cf_lsu_after_ic", 32'(d - is_l), 32'(LINE + 2 + nbytes(sz) + (we ? 1 : 2)));
        end
        ref_last_lsu = !lsu_wins;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ic_out_en"}, 32'(ic_out_en), 32'd0);
        chk({tag, "_ic_content"}, 32'(ic_content), 32'd0);
        chk({tag, "_lsu_done"}, 32'(lsu_done), 32'd0);
        chk({tag, "_lsu_rdata"}, lsu_rdata, 32'd0);
        chk({tag, "_mem_a"}, 32'(mem_a), 32'd0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, "_mem_dout"}, 32'(mem_dout), 32'd0);
    endtask

    function automatic logic [16:0] pick_addr();
        case ($urandom_range(0, 2))
            0:       return 17'h1FFFC + 17'($urandom_range(0, 3));
            1:       return 17'($urandom_range(0, 63));
            default: return 17'($urandom);
        endcase
    endfunction

    initial begin
        int is, f, l, d;
        bit ok;
        for (int i = 0; i < MEMSZ; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;
        mon_en = 1'b1;
        gap();

        // Scenario 1: icache line fill.
        set_byte(17'h00100, 8'h13); set_byte(17'h00101, 8'h05);
        set_byte(17'h00102, 8'h00); set_byte(17'h00103, 8'h00);
        ic_only(17'h00100);
        chk("s1_idle_mem_a", 32'(mem_a), 32'd0);
        gap();

        // Scenario 2: misaligned word load.
        set_byte(17'h00202, 8'hAA); set_byte(17'h00203, 8'hBB);
        set_byte(17'h00204, 8'hCC); set_byte(17'h00205, 8'hDD);
        lsu_only(1'b0, 17'h00202, 2'd2, 32'h0);
        chk("s2_rdata", lsu_rdata, 32'hDDCCBBAA);
        gap();

        // Scenario 3: half store straddling the address wrap.
        lsu_only(1'b1, 17'h1FFFF, 2'd1, 32'h0000BEEF);
        gap();
        chk("s3_ram_hi", 32'(ram[17'h1FFFF]), 32'h0000_00EF);
        chk("s3_ram_lo", 32'(ram[17'h00000]), 32'h0000_00BE);

        // Scenario 4: simultaneous requests, then again after an LSU-only grant.
        conflict(17'h00300, 1'b0, 17'h00310, 2'd0, 32'h0);
        gap();
        lsu_only(1'b0, 17'h00320, 2'd0, 32'h0);
        gap();
        conflict(17'h00400, 1'b0, 17'h00410, 2'd0, 32'h0);
        gap();

        // Scenario 5: reset after two icache beats, then a clean refill.
        ic_expect(17'h00500);
        ic_base = 17'h00500;
        ic_get_en = 1'b1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ic_rx == 2) begin ok = 1; break; end
        end
        if (!ok) fail("s5_ic_timeout");
        rst = 1'b1;
        ic_get_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ic_q.delete();
        chk_reset_outputs("s5");
        ref_last_lsu = 1'b0;
        gap();
        ic_only(17'h00500);
        gap();

        // Reset during a word store: only the first byte reaches RAM.
        set_byte(17'h00600, 8'h11); set_byte(17'h00601, 8'h22);
        set_byte(17'h00602, 8'h33); set_byte(17'h00603, 8'h44);
        ref_mem[17'h00600] = 8'h5A;
        wr_q.push_back('{a: 17'h00600, d: 8'h5A});
        lsu_we = 1'b1; lsu_addr = 17'h00600; lsu_size = 2'd2; lsu_wdata = 32'hC3B2A15A;
        lsu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        lsu_req = 1'b0;
        @(negedge clk);
        chk("s5_wr_in_rst", 32'(mem_wr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("s5w");
        ref_last_lsu = 1'b0;
        gap();
        lsu_only(1'b0, 17'h00600, 2'd2, 32'h0);
        gap();

        // Random mix.
        for (int it = 0; it < 60; it++) begin
            logic [16:0] rb, ra;
            logic        rwe;
            logic [1:0]  rsz;
            logic [31:0] rwd;
            rb  = pick_addr();
            ra  = pick_addr();
            rwe = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            rwd = $urandom;
            case ($urandom_range(0, 2))
                0:       ic_only(rb);
                1:       lsu_only(rwe, ra, rsz, rwd);
                default: conflict(rb, rwe, ra, rsz, rwd);
            endcase
            gap();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("end_ic_q", 32'(ic_q.size()), 32'd0);
        chk("end_lsu_q", 32'(lsu_q.size()), 32'd0);
        chk("end_wr_q", 32'(wr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
